alu_arbiter_seq: RTL and testbench
==================================

Name: alu_arbiter_seq

Overview:
- Sequencer and round-robin arbiter that shares one combinational ALU (N-bit operands, 4-bit ALUControl, flags negativo/cero/acarreo) between two requesters.
- Accepts an operation over a valid/ready handshake and drives registered, stable operands to the ALU for a fixed settle time.
- Captures Y and the flags, then returns them over a valid/ready response channel tagged with the requester id.
- Sits between switch/button front-ends or test sources and the ALU instance; the 7-segment decoders read resp_y/resp_carry.

Parameters:
- N, 3, operand/result width; must match the ALU instance's N.
- LAT, 1, ALU settle cycles in EXEC (1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  N  requester 0 operands
- req0_op  in  4  requester 0 ALUControl code
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- alu_a, alu_b  out  N  registered operands to ALU
- alu_ctrl  out  4  registered ALUControl to ALU
- alu_y  in  N  ALU result
- alu_neg, alu_zero, alu_carry  in  1  ALU flags
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_id  out  1  requester that issued the result
- resp_y  out  N  captured result
- resp_neg, resp_zero, resp_carry  out  1  captured flags
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0, async):
  - State = IDLE.
  - All outputs = 0; all internal registers = 0.
  - last_grant = 1, so requester 0 wins the first contention.
  - Asserting reset mid-operation aborts the operation; no response is produced.
- States:
  - IDLE:
    - Grant = the single valid requester; if both are valid, the one != last_grant.
    - reqX_ready = 1 combinationally, only for the granted X; both readies are 0 outside IDLE.
    - On valid&&ready: latch a/b/op into alu_a/alu_b/alu_ctrl, latch id, last_grant := id, cnt := 0, go to EXEC.
  - EXEC:
    - Operands are held constant.
    - cnt increments each cycle.
    - When cnt == LAT-1: capture alu_y and flags into resp_* at that edge, then go to RESP.
  - RESP:
    - resp_valid = 1, with resp_* stable.
    - On resp_ready=1: go to IDLE.
    - resp_valid deasserts the following cycle; resp_* hold their last values.
- Latency and throughput:
  - Accept at edge T; resp_valid rises at edge T+LAT.
  - Minimum spacing between accepts is LAT+2 cycles (no IDLE bypass).
- Other rules:
  - alu_* change only on an accept edge and are never modified outside IDLE.
  - A requester must hold valid and payload until its ready; dropping valid before ready is legal and causes no transfer.
  - No arithmetic is done in this block; widths pass through unchanged.
  - resp_ready while not in RESP is ignored.
  - Simultaneous valids in IDLE: exactly one ready is asserted; the other requester waits at least until the next return to IDLE.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs op_count[7:0] and carry_count[7:0], both reset to 0.
  - op_count +1 on every response handshake (resp_valid&&resp_ready).
  - carry_count +1 on a handshake whose resp_carry=1.
  - Both saturate at 8'hFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Bench ALU stub, used by every scenario:
  - alu_y = (alu_a+alu_b) mod 8.
  - alu_carry = bit 3 of the sum.
  - alu_zero = (alu_y==0).
  - alu_neg = alu_y[2].
  - N=3, LAT=1.
- Reset then idle: rst_n low for 2 cycles -> all outputs 0, busy=0; req0_valid=1 on the first cycle after release -> req0_ready=1 that cycle.
- Single op: req0 a=3, b=2, op=4'h0, accepted at edge T -> resp_valid=1 from T+1, resp_y=5, resp_id=0, resp_neg=1, resp_zero=0, resp_carry=0; alu_a=3 held through EXEC.
- Round robin:
  - Both valid continuously, resp_ready=1: grants go 0,1,0,1.
  - req1 a=7, b=1 -> resp_y=0, zero=1, carry=1, id=1.
  - Accepts are 3 cycles apart.
- Backpressure:
  - resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_* stable, both readies 0, busy=1.
  - Raise resp_ready -> IDLE next cycle.
- Reset mid-EXEC with LAT=4: assert rst_n=0 at cnt=2 -> outputs 0 immediately (async), no response after release, next grant goes to req0.
- ALU_ARB_STATS_EN: 300 handshakes with a=7, b=1 -> op_count=carry_count=8'hFF (saturated).

Source files
------------

// File: rtl/alu_arbiter_seq.sv
// alu_arbiter_seq: round-robin sequencer that shares one combinational ALU
// between two requesters. Operations are accepted over a valid/ready
// handshake, presented to the ALU on registered operands for LAT settle
// cycles, and the captured result is returned on a valid/ready response
// channel tagged with the requester id.
//
// Optional feature: define ALU_ARB_STATS_EN to add the op_count and
// carry_count saturating statistics outputs.
module alu_arbiter_seq #(
  parameter int N   = 3,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  // requester 0
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_op,
  // requester 1
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_op,
  // shared ALU
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [N-1:0] alu_y,
  input  logic         alu_neg,
  input  logic         alu_zero,
  input  logic         alu_carry,
  // response channel
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [N-1:0] resp_y,
  output logic         resp_neg,
  output logic         resp_zero,
  output logic         resp_carry,
  output logic         busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]   op_count,
  output logic [7:0]   carry_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Settle counter is 4 bits wide, enough for LAT up to 15.
  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_e       state_q;
  logic         last_grant_q;
  logic [3:0]   cnt_q;
  logic [3:0]   cnt_d;
  logic [N-1:0] alu_a_q;
  logic [N-1:0] alu_b_q;
  logic [3:0]   alu_ctrl_q;
  logic         resp_valid_q;
  logic         resp_id_q;
  logic [N-1:0] resp_y_q;
  logic         resp_neg_q;
  logic         resp_zero_q;
  logic         resp_carry_q;
  logic         busy_q;

  logic         in_idle;
  logic         gnt_any;
  logic         gnt_id;
  logic         accept;
  logic         exec_done;
  logic         resp_hs;
  logic [N-1:0] sel_a;
  logic [N-1:0] sel_b;
  logic [3:0]   sel_op;

  // Arbitration: single valid requester wins; on contention the requester
  // that was not granted last time wins. Readies are gated by reset so every
  // output reads zero while rst_n is low.
  always_comb begin
    in_idle = rst_n && (state_q == IDLE);
    gnt_any = req0_valid || req1_valid;
    gnt_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_grant_q;
    end else if (req1_valid) begin
      gnt_id = 1'b1;
    end
    req0_ready = in_idle && gnt_any && !gnt_id;
    req1_ready = in_idle && gnt_any && gnt_id;
    accept     = req0_ready || req1_ready;
    sel_a      = gnt_id ? req1_a  : req0_a;
    sel_b      = gnt_id ? req1_b  : req0_b;
    sel_op     = gnt_id ? req1_op : req0_op;
    cnt_d      = cnt_q + 4'd1;
    exec_done  = (cnt_q == LAT_M1);
    resp_hs    = (state_q == RESP) && resp_ready;
  end

  // Sequencer FSM: owns the ALU operand registers, the settle counter and
  // every registered output of the response channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_y_q     <= '0;
      resp_neg_q   <= 1'b0;
      resp_zero_q  <= 1'b0;
      resp_carry_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            alu_a_q      <= sel_a;
            alu_b_q      <= sel_b;
            alu_ctrl_q   <= sel_op;
            resp_id_q    <= gnt_id;
            last_grant_q <= gnt_id;
            cnt_q        <= 4'd0;
            busy_q       <= 1'b1;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          cnt_q <= cnt_d;
          if (exec_done) begin
            resp_y_q     <= alu_y;
            resp_neg_q   <= alu_neg;
            resp_zero_q  <= alu_zero;
            resp_carry_q <= alu_carry;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_y     = resp_y_q;
  assign resp_neg   = resp_neg_q;
  assign resp_zero  = resp_zero_q;
  assign resp_carry = resp_carry_q;
  assign busy       = busy_q;

`ifdef ALU_ARB_STATS_EN
  logic [7:0] op_count_q;
  logic [7:0] carry_count_q;

  // Saturating counters of completed responses and of those carrying out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q    <= 8'd0;
      carry_count_q <= 8'd0;
    end else if (resp_hs) begin
      if (op_count_q != 8'hFF) begin
        op_count_q <= op_count_q + 8'd1;
      end
      if (resp_carry_q && (carry_count_q != 8'hFF)) begin
        carry_count_q <= carry_count_q + 8'd1;
      end
    end
  end

  assign op_count    = op_count_q;
  assign carry_count = carry_count_q;
`else
  // Handshake decode only feeds the statistics counters.
  logic unused_hs;
  assign unused_hs = resp_hs;
`endif

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Bench for alu_arbiter_seq: adder ALU stub, directed table, hand sequences
// for multi-cycle corners (LAT=1 and LAT=4 instances) and a randomized run
// against a transaction-timeline reference model.
module tb_alu_arbiter_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r0v = 1'b0, r1v = 1'b0, rr = 1'b0;
  logic [2:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0;
  logic [3:0] r0op = '0, r1op = '0;

  always #5 clk = ~clk;

  // DUT with LAT=1
  logic       rdy0_1, rdy1_1, rv_1, rid_1, rn_1, rz_1, rc_1, busy_1;
  logic [2:0] aa_1, ab_1, ry_1, y_1;
  logic [3:0] actl_1, s_1;
  logic [7:0] opc_1, cc_1;
  assign s_1 = {1'b0, aa_1} + {1'b0, ab_1};
  assign y_1 = s_1[2:0];

  alu_arbiter_seq #(.N(3), .LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_ready(rdy0_1), .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
    .req1_valid(r1v), .req1_ready(rdy1_1), .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
    .alu_a(aa_1), .alu_b(ab_1), .alu_ctrl(actl_1),
    .alu_y(y_1), .alu_neg(y_1[2]), .alu_zero(y_1 == 3'd0), .alu_carry(s_1[3]),
    .resp_valid(rv_1), .resp_ready(rr), .resp_id(rid_1), .resp_y(ry_1),
    .resp_neg(rn_1), .resp_zero(rz_1), .resp_carry(rc_1), .busy(busy_1)
`ifdef ALU_ARB_STATS_EN
    , .op_count(opc_1), .carry_count(cc_1)
`endif
  );
`ifndef ALU_ARB_STATS_EN
  assign opc_1 = 8'd0;
  assign cc_1  = 8'd0;
`endif

  // DUT with LAT=4, sharing the stimulus
  logic       rdy0_4, rdy1_4, rv_4, rid_4, rn_4, rz_4, rc_4, busy_4;
  logic [2:0] aa_4, ab_4, ry_4, y_4;
  logic [3:0] actl_4, s_4;
  logic [7:0] opc_4, cc_4;
  assign s_4 = {1'b0, aa_4} + {1'b0, ab_4};
  assign y_4 = s_4[2:0];

  alu_arbiter_seq #(.N(3), .LAT(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_ready(rdy0_4), .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
    .req1_valid(r1v), .req1_ready(rdy1_4), .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
    .alu_a(aa_4), .alu_b(ab_4), .alu_ctrl(actl_4),
    .alu_y(y_4), .alu_neg(y_4[2]), .alu_zero(y_4 == 3'd0), .alu_carry(s_4[3]),
    .resp_valid(rv_4), .resp_ready(rr), .resp_id(rid_4), .resp_y(ry_4),
    .resp_neg(rn_4), .resp_zero(rz_4), .resp_carry(rc_4), .busy(busy_4)
`ifdef ALU_ARB_STATS_EN
    , .op_count(opc_4), .carry_count(cc_4)
`endif
  );
`ifndef ALU_ARB_STATS_EN
  assign opc_4 = 8'd0;
  assign cc_4  = 8'd0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // wait (at negedges) for u1 resp_valid, bounded
  task automatic wait_rv1(input string nm);
    int n;
    n = 0;
    while (rv_1 !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (rv_1 !== 1'b1) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    logic       v0; logic [2:0] a0; logic [2:0] b0;
    logic       v1; logic [2:0] a1; logic [2:0] b1;
    logic       e_id; logic [2:0] e_y; logic e_n; logic e_z; logic e_c;
  } vec_t;

  vec_t tbl[6];

  // random-run model state
  bit         m_out, m_last, m_r0, m_r1, m_any, m_id, m_rv, took0, took1;
  int         m_acc, cyc, m_opc, m_cc;
  logic [2:0] t_a, t_b;
  logic [3:0] t_op, t_sum;
  logic       t_id;
  int         accs[$];
  int         gids[$];
  int         hs;

  initial begin
    // vectors applied after a reset (last_grant = 1)
    tbl[0] = '{1, 3'd3, 3'd2, 0, 3'd0, 3'd0, 0, 3'd5, 1, 0, 0};
    tbl[1] = '{1, 3'd1, 3'd1, 1, 3'd7, 3'd1, 1, 3'd0, 0, 1, 1};
    tbl[2] = '{1, 3'd4, 3'd4, 1, 3'd2, 3'd2, 0, 3'd0, 0, 1, 1};
    tbl[3] = '{0, 3'd0, 3'd0, 1, 3'd6, 3'd1, 1, 3'd7, 1, 0, 0};
    tbl[4] = '{1, 3'd5, 3'd6, 1, 3'd0, 3'd0, 0, 3'd3, 0, 0, 1};
    tbl[5] = '{1, 3'd5, 3'd6, 1, 3'd0, 3'd0, 1, 3'd0, 0, 1, 0};

    // ---- reset then idle ----
    rst_n = 1'b0;
    r0v = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy_1, 0);
    chk("rst_rv", rv_1, 0);
    chk("rst_rdy0", rdy0_1, 0);
    chk("rst_alu_a", aa_1, 0);
    chk("rst_resp_y", ry_1, 0);
    chk("rst_opc", opc_1, 0);
    r0v = 1'b0;
    rst_n = 1'b1;
    r0v = 1'b1; r0a = 3'd3; r0b = 3'd2; r0op = 4'h0;
    #1;
    chk("idle_rdy0", rdy0_1, 1);
    chk("idle_rdy1", rdy1_1, 0);

    // ---- single op: accepted at the next posedge ----
    step();
    r0v = 1'b0;
    chk("single_exec_rv", rv_1, 0);
    chk("single_exec_busy", busy_1, 1);
    chk("single_exec_alu_a", aa_1, 3);
    chk("single_exec_alu_b", ab_1, 2);
    step();
    chk("single_rv", rv_1, 1);
    chk("single_y", ry_1, 5);
    chk("single_id", rid_1, 0);
    chk("single_neg", rn_1, 1);
    chk("single_zero", rz_1, 0);
    chk("single_carry", rc_1, 0);
    chk("single_alu_a_held", aa_1, 3);
    rr = 1'b1;
    step();
    rr = 1'b0;
    chk("single_done_busy", busy_1, 0);
    chk("single_done_rv", rv_1, 0);
    chk("single_hold_y", ry_1, 5);

    // ---- table-driven vectors ----
    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      r0v = tbl[i].v0; r0a = tbl[i].a0; r0b = tbl[i].b0; r0op = 4'(i);
      r1v = tbl[i].v1; r1a = tbl[i].a1; r1b = tbl[i].b1; r1op = 4'(i + 8);
      #1;
      chk($sformatf("tbl%0d_rdy0", i), rdy0_1, !tbl[i].e_id);
      chk($sformatf("tbl%0d_rdy1", i), rdy1_1, tbl[i].e_id);
      step();
      r0v = 1'b0; r1v = 1'b0;
      chk($sformatf("tbl%0d_ctrl", i), actl_1, tbl[i].e_id ? i + 8 : i);
      wait_rv1($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_id", i), rid_1, tbl[i].e_id);
      chk($sformatf("tbl%0d_y", i), ry_1, tbl[i].e_y);
      chk($sformatf("tbl%0d_flags", i), {rn_1, rz_1, rc_1}, {tbl[i].e_n, tbl[i].e_z, tbl[i].e_c});
      rr = 1'b1;
      step();
      rr = 1'b0;
      chk($sformatf("tbl%0d_idle", i), busy_1, 0);
    end

    // ---- round robin, both valid continuously ----
    do_reset(1);
    r0v = 1'b1; r0a = 3'd1; r0b = 3'd2; r0op = 4'h0;
    r1v = 1'b1; r1a = 3'd7; r1b = 3'd1; r1op = 4'h0;
    rr = 1'b1;
    accs.delete(); gids.delete();
    for (int c = 0; c < 40 && accs.size() < 4; c++) begin
      #1;
      if (rv_1 === 1'b1 && rid_1 === 1'b1) begin
        chk("rr_r1_y", ry_1, 0);
        chk("rr_r1_flags", {rz_1, rc_1}, 2'b11);
      end
      if (rdy0_1 === 1'b1 || rdy1_1 === 1'b1) begin
        accs.push_back(c);
        gids.push_back(rdy1_1 ? 1 : 0);
      end
      step();
    end
    chk("rr_count", accs.size(), 4);
    if (accs.size() == 4) begin
      for (int k = 0; k < 4; k++) chk($sformatf("rr_grant%0d", k), gids[k], k % 2);
      for (int k = 1; k < 4; k++) chk($sformatf("rr_space%0d", k), accs[k] - accs[k-1], 3);
    end
    r0v = 1'b0; r1v = 1'b0;
    repeat (3) step();

    // ---- backpressure ----
    rr = 1'b0;
    r0v = 1'b1; r0a = 3'd3; r0b = 3'd4;
    step();
    r0v = 1'b0;
    wait_rv1("bp");
    r0v = 1'b1; r1v = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rv", rv_1, 1);
      chk("bp_y", ry_1, 7);
      chk("bp_neg", rn_1, 1);
      chk("bp_readies", {rdy0_1, rdy1_1}, 2'b00);
      chk("bp_busy", busy_1, 1);
      step();
    end
    r0v = 1'b0; r1v = 1'b0;
    rr = 1'b1;
    step();
    rr = 1'b0;
    chk("bp_release_busy", busy_1, 0);
    chk("bp_release_rv", rv_1, 0);

    // ---- reset mid-EXEC on the LAT=4 instance ----
    do_reset(1);
    r0v = 1'b1; r0a = 3'd3; r0b = 3'd2; r0op = 4'h5;
    #1;
    chk("l4_rdy0", rdy0_4, 1);
    step();                 // cnt=0
    r0v = 1'b0;
    step();                 // cnt=1
    step();                 // cnt=2
    chk("l4_busy_pre", busy_4, 1);
    rst_n = 1'b0;
    #1;
    chk("l4_rst_busy", busy_4, 0);
    chk("l4_rst_alu", {aa_4, ab_4, actl_4}, 0);
    chk("l4_rst_rv", rv_4, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("l4_no_resp", {rv_4, busy_4}, 2'b00);
    end
    r0v = 1'b1; r1v = 1'b1;
    #1;
    chk("l4_next_grant", {rdy0_4, rdy1_4}, 2'b10);
    r0v = 1'b0; r1v = 1'b0;

    // ---- randomized run against the reference model ----
    do_reset(1);
    m_out = 0; m_last = 1; cyc = 0; m_opc = 0; m_cc = 0;
    took0 = 0; took1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(r0v && !took0 && $urandom_range(3) != 0)) begin
        r0v = 1'($urandom_range(1)); r0a = 3'($urandom); r0b = 3'($urandom); r0op = 4'($urandom);
      end
      if (!(r1v && !took1 && $urandom_range(3) != 0)) begin
        r1v = 1'($urandom_range(1)); r1a = 3'($urandom); r1b = 3'($urandom); r1op = 4'($urandom);
      end
      rr = 1'($urandom_range(1));
      #1;
      m_any = !m_out && (r0v || r1v);
      m_id  = (r0v && r1v) ? !m_last : r1v;
      m_r0  = m_any && !m_id;
      m_r1  = m_any && m_id;
      m_rv  = m_out && (cyc >= m_acc + 1);
      chk("rnd_rdy", {rdy0_1, rdy1_1}, {m_r0, m_r1});
      chk("rnd_busy", busy_1, m_out);
      chk("rnd_rv", rv_1, m_rv);
      if (m_out) chk("rnd_alu", {aa_1, ab_1, actl_1}, {t_a, t_b, t_op});
      if (m_rv) begin
        t_sum = {1'b0, t_a} + {1'b0, t_b};
        chk("rnd_resp", {rid_1, ry_1, rn_1, rz_1, rc_1},
            {t_id, t_sum[2:0], t_sum[2], t_sum[2:0] == 3'd0, t_sum[3]});
      end
      took0 = m_r0; took1 = m_r1;
      if (m_rv && rr) begin
        m_out = 0;
        if (m_opc < 255) m_opc++;
        if (t_sum[3] && m_cc < 255) m_cc++;
      end else if (m_any) begin
        m_out = 1; m_acc = cyc + 1; m_last = m_id; t_id = m_id;
        t_a  = m_id ? r1a : r0a;
        t_b  = m_id ? r1b : r0b;
        t_op = m_id ? r1op : r0op;
      end
      step();
      cyc++;
    end
    r0v = 1'b0; r1v = 1'b0; rr = 1'b0;
`ifdef ALU_ARB_STATS_EN
    chk("rnd_op_count", opc_1, m_opc);
    chk("rnd_carry_count", cc_1, m_cc);

    // ---- statistics saturation ----
    do_reset(1);
    r0v = 1'b1; r0a = 3'd7; r0b = 3'd1; r0op = 4'h0;
    rr = 1'b1;
    hs = 0;
    for (int c = 0; c < 1200 && hs < 300; c++) begin
      #1;
      if (hs == 5 && rv_1 !== 1'b1 && busy_1 === 1'b0) begin
        chk("stat_op5", opc_1, 5);
        chk("stat_cc5", cc_1, 5);
      end
      if (rv_1 === 1'b1) hs++;
      step();
    end
    r0v = 1'b0;
    repeat (6) step();
    chk("stat_hs_seen", hs, 300);
    chk("stat_op_sat", opc_1, 8'hFF);
    chk("stat_cc_sat", cc_1, 8'hFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
